ibex_l2_rf_xfer_ctrl: RTL

Sequencer that moves architectural register contents between the core register file and the L2 register file. It sits directly upstream of the L2 register file, drives its single address/write-data/write-enable port, and consumes its combinational read data. On a save request it copies registers 1..NumWords-1 from the core RF into L2. On a restore request it copies them back, one register per cycle.

---
 rtl/ibex_l2_rf_xfer_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ibex_l2_rf_xfer_ctrl.sv
// ibex_l2_rf_xfer_ctrl
// Copies registers x1..x(NumWords-1) from the core register file into the L2
// register file (save) or back again (restore), one register per cycle.
// Both read-data paths are combinational through to the write-data outputs.
//
// Optional feature: define IBEX_L2_RF_CHECKSUM_EN to keep an XOR checksum of
// each transfer and flag a restore whose checksum differs from the last save.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for save_req_i / restore_req_i, all outputs quiet
// SAVE    | core RF[idx_q] -> L2[idx_q], one word per cycle
// RESTORE | L2[idx_q] -> core RF[idx_q], one word per cycle
// DONE    | one-cycle completion pulse, then back to IDLE
module ibex_l2_rf_xfer_ctrl #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 28
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 save_req_i,
  input  logic                 restore_req_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4:0]           rf_raddr_o,
  input  logic [DataWidth-1:0] rf_rdata_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic [4:0]           l2_addr_o,
  output logic [DataWidth-1:0] l2_wdata_o,
  output logic                 l2_we_o,
  input  logic [DataWidth-1:0] l2_rdata_i,
  output logic                 csum_err_o
);

  localparam logic [4:0] LastIdx = 5'(NumWords - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;

  // Transfer start and last-word strobes, shared with the checksum logic.
  logic       start_s;
  logic       last_s;

  // State and index registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and port outputs; an abort suppresses the write of its cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    rf_raddr_o = 5'd0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = '0;
    rf_we_o    = 1'b0;
    l2_addr_o  = 5'd0;
    l2_wdata_o = '0;
    l2_we_o    = 1'b0;
    start_s    = 1'b0;
    last_s     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (save_req_i) begin
          state_d = SAVE;
          idx_d   = 5'd1;
          start_s = 1'b1;
        end else if (restore_req_i) begin
          state_d = RESTORE;
          idx_d   = 5'd1;
          start_s = 1'b1;
        end
      end
      SAVE: begin
        busy_o = 1'b1;
        if (abort_i) begin
          state_d = IDLE;
          idx_d   = 5'd0;
        end else begin
          rf_raddr_o = idx_q;
          l2_addr_o  = idx_q;
          l2_wdata_o = rf_rdata_i;
          l2_we_o    = 1'b1;
          idx_d      = idx_q + 5'd1;
          if (idx_q == LastIdx) begin
            state_d = DONE;
            last_s  = 1'b1;
          end
        end
      end
      RESTORE: begin
        busy_o = 1'b1;
        if (abort_i) begin
          state_d = IDLE;
          idx_d   = 5'd0;
        end else begin
          l2_addr_o  = idx_q;
          rf_waddr_o = idx_q;
          rf_wdata_o = l2_rdata_i;
          rf_we_o    = 1'b1;
          idx_d      = idx_q + 5'd1;
          if (idx_q == LastIdx) begin
            state_d = DONE;
            last_s  = 1'b1;
          end
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
        idx_d   = 5'd0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 5'd0;
      end
    endcase
  end

`ifdef IBEX_L2_RF_CHECKSUM_EN
  logic [DataWidth-1:0] csum_q, csum_d;
  logic [DataWidth-1:0] saved_csum_q, saved_csum_d;
  logic                 saved_valid_q, saved_valid_d;
  logic                 csum_err_q, csum_err_d;
  logic [DataWidth-1:0] csum_next;

  // Checksum registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      csum_q        <= '0;
      saved_csum_q  <= '0;
      saved_valid_q <= 1'b0;
      csum_err_q    <= 1'b0;
    end else begin
      csum_q        <= csum_d;
      saved_csum_q  <= saved_csum_d;
      saved_valid_q <= saved_valid_d;
      csum_err_q    <= csum_err_d;
    end
  end

  // Accumulate the moved words; latch or compare the total on the last word.
  // An abort never reaches last_s, so the saved checksum and flag survive it.
  always_comb begin
    csum_d        = csum_q;
    saved_csum_d  = saved_csum_q;
    saved_valid_d = saved_valid_q;
    csum_err_d    = csum_err_q;
    csum_next     = csum_q;
    if (start_s) begin
      csum_d     = '0;
      csum_err_d = 1'b0;
    end else if (l2_we_o) begin
      csum_next = csum_q ^ rf_rdata_i;
      csum_d    = csum_next;
      if (last_s) begin
        saved_csum_d  = csum_next;
        saved_valid_d = 1'b1;
      end
    end else if (rf_we_o) begin
      csum_next = csum_q ^ l2_rdata_i;
      csum_d    = csum_next;
      if (last_s) begin
        csum_err_d = !saved_valid_q || (csum_next != saved_csum_q);
      end
    end
  end

  assign csum_err_o = csum_err_q;
`else
  assign csum_err_o = 1'b0;
`endif

endmodule
